// File: rtl/i2s_sample_bridge_pkg.sv
// ---------------------------------------------------------------------------
// i2s_sample_bridge_pkg
//   Shared definitions for the I2S sample bridge: bridge state encoding,
//   bit/fall counter width and a saturating counter increment helper.
// ---------------------------------------------------------------------------
package i2s_sample_bridge_pkg;

    // Counters cover slots up to 64 BCLKs; they stick at the maximum value.
    localparam int BR_CNT_WIDTH = 6;
    localparam logic [BR_CNT_WIDTH-1:0] BR_CNT_MAX = '1;

    typedef enum logic [1:0] {
        BR_STATE_SYNC  = 2'd0,
        BR_STATE_LEFT  = 2'd1,
        BR_STATE_RIGHT = 2'd2
    } br_state_e;

    function automatic logic [BR_CNT_WIDTH-1:0] br_cnt_inc(input logic [BR_CNT_WIDTH-1:0] c);
        return (c == BR_CNT_MAX) ? c : c + BR_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// ---------------------------------------------------------------------------
// i2s_edge_sync
//   Brings one asynchronous codec signal into the clk domain through a
//   STAGES-deep flop chain and derives single-cycle rise/fall strobes from
//   the synchronised value.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   async_i    : asynchronous input
//   sync_o     : synchronised level
//   rise_o     : one-clk strobe on a 0->1 of sync_o
//   fall_o     : one-clk strobe on a 1->0 of sync_o
// ---------------------------------------------------------------------------
module i2s_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2s_sample_bridge.sv
// ---------------------------------------------------------------------------
// i2s_sample_bridge
//   Codec-side bridge for the DSP engine. Deserialises the left ADC slot of
//   an I2S stream into in_sample (+ sample_ready pulse) and serialises the
//   engine's out_sample on the next left DAC slot. The codec is bus master.
//   Build option I2S_BRIDGE_STEREO_DUP_EN: when defined the right DAC slot
//   repeats the left word; otherwise the right DAC slot is driven 0.
// Ports:
//   clk, reset      : system clock (>= 8x BCLK), synchronous active-high reset
//   i2s_bclk/lrclk  : codec bit clock / word select (0 = left), asynchronous
//   i2s_adc         : ADC serial data in
//   i2s_dac         : DAC serial data out
//   in_sample       : latest left ADC sample, held until next capture
//   sample_ready    : one-clk pulse, in_sample is new
//   out_sample      : engine output sample
//   engine_ready    : rising edge marks out_sample valid
//   underrun        : one-clk pulse, left slot started with no new sample
//   underrun_count  : saturating count of underrun pulses
//   frame_error     : one-clk pulse, short slot detected
// ---------------------------------------------------------------------------
module i2s_sample_bridge
    import i2s_sample_bridge_pkg::*;
#(
    parameter int data_width  = 16,
    parameter int slot_width  = 32,
    parameter int sync_stages = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_adc,
    output logic                  i2s_dac,
    output logic [data_width-1:0] in_sample,
    output logic                  sample_ready,
    input  logic [data_width-1:0] out_sample,
    input  logic                  engine_ready,
    output logic                  underrun,
    output logic [15:0]           underrun_count,
    output logic                  frame_error
);

    if (slot_width <= data_width || slot_width > 64) begin : g_bad_cfg
        $error("i2s_sample_bridge: slot_width must be data_width+1..64");
    end

    localparam logic [BR_CNT_WIDTH-1:0] DW_C  = BR_CNT_WIDTH'(data_width);
    localparam logic [BR_CNT_WIDTH-1:0] DW_M1 = BR_CNT_WIDTH'(data_width - 1);
    localparam int IDX_W = (data_width > 1) ? $clog2(data_width) : 1;

`ifdef I2S_BRIDGE_STEREO_DUP_EN
    localparam logic RIGHT_DRIVE = 1'b1;
`else
    localparam logic RIGHT_DRIVE = 1'b0;
`endif

    // ---- synchronisers --------------------------------------------------
    logic bclk_s, bclk_rise, bclk_fall, lr_s, adc_s;

    i2s_edge_sync #(.STAGES(sync_stages)) u_sync_bclk (
        .clk(clk), .reset(reset), .async_i(i2s_bclk),
        .sync_o(bclk_s), .rise_o(bclk_rise), .fall_o(bclk_fall)
    );
    i2s_edge_sync #(.STAGES(sync_stages)) u_sync_lrclk (
        .clk(clk), .reset(reset), .async_i(i2s_lrclk),
        .sync_o(lr_s), .rise_o(), .fall_o()
    );
    i2s_edge_sync #(.STAGES(sync_stages)) u_sync_adc (
        .clk(clk), .reset(reset), .async_i(i2s_adc),
        .sync_o(adc_s), .rise_o(), .fall_o()
    );

    // ---- RX state machine -----------------------------------------------
    br_state_e                 state_q;
    logic                      lr_prev_q;
    logic [BR_CNT_WIDTH-1:0]   rc_q;
    logic [data_width-1:0]     rx_shift_q;
    logic [data_width-1:0]     in_sample_q;
    logic                      rdy_pend_q;
    logic                      sample_ready_q;
    logic                      frame_error_q;
    // A slot start seen on a rise is acted on by the TX side at the next fall.
    logic                      slot_pend_q;
    logic                      slot_left_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= BR_STATE_SYNC;
            lr_prev_q      <= 1'b0;
            rc_q           <= '0;
            rx_shift_q     <= '0;
            in_sample_q    <= '0;
            rdy_pend_q     <= 1'b0;
            sample_ready_q <= 1'b0;
            frame_error_q  <= 1'b0;
            slot_pend_q    <= 1'b0;
            slot_left_q    <= 1'b0;
        end else begin
            rdy_pend_q     <= 1'b0;
            frame_error_q  <= 1'b0;
            sample_ready_q <= rdy_pend_q;
            if (bclk_fall) slot_pend_q <= 1'b0;

            if (bclk_rise) begin
                if (lr_s != lr_prev_q) begin
                    lr_prev_q <= lr_s;
                    rc_q      <= '0;
                    // The slot just ended never reached its last data bit.
                    if (state_q != BR_STATE_SYNC && rc_q < DW_C) frame_error_q <= 1'b1;
                    case (state_q)
                        BR_STATE_SYNC:  if (!lr_s) state_q <= BR_STATE_LEFT;
                        BR_STATE_LEFT:  state_q <= BR_STATE_RIGHT;
                        default:        state_q <= BR_STATE_LEFT;
                    endcase
                    if (state_q != BR_STATE_SYNC || !lr_s) begin
                        slot_pend_q <= 1'b1;
                        slot_left_q <= !lr_s;
                    end
                end else begin
                    rc_q <= br_cnt_inc(rc_q);
                    // Bits arrive one BCLK after the lrclk change, MSB first.
                    if (rc_q < DW_C) rx_shift_q <= {rx_shift_q[data_width-2:0], adc_s};
                    if (state_q == BR_STATE_LEFT && rc_q == DW_M1) begin
                        in_sample_q <= {rx_shift_q[data_width-2:0], adc_s};
                        rdy_pend_q  <= 1'b1;
                    end
                end
            end
        end
    end

    // ---- TX hold / shift / drive ----------------------------------------
    logic                    er_q;
    logic                    er_rise;
    logic [data_width-1:0]   tx_hold_q;
    logic                    tx_valid_q;
    logic [data_width-1:0]   tx_shift_q;
    logic [BR_CNT_WIDTH-1:0] fc_q;
    logic                    drive_q;
    logic                    dac_q;
    logic                    underrun_q;
    logic [15:0]             urun_cnt_q;
    logic [BR_CNT_WIDTH-1:0] fc_d;
    logic [IDX_W-1:0]        tx_idx;
    logic                    dac_d;

    assign er_rise = engine_ready & ~er_q;
    assign fc_d    = br_cnt_inc(fc_q);
    assign tx_idx  = IDX_W'(DW_C - fc_d);
    // fc 1..data_width maps to bits MSB..LSB of the loaded word.
    assign dac_d   = (drive_q && fc_d <= DW_C) ? tx_shift_q[tx_idx] : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            er_q       <= 1'b0;
            tx_hold_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_shift_q <= '0;
            fc_q       <= '0;
            drive_q    <= 1'b0;
            dac_q      <= 1'b0;
            underrun_q <= 1'b0;
            urun_cnt_q <= '0;
        end else begin
            er_q       <= engine_ready;
            underrun_q <= 1'b0;

            if (bclk_fall && slot_pend_q) begin
                fc_q  <= '0;
                dac_q <= 1'b0;
                if (slot_left_q) begin
                    drive_q <= 1'b1;
                    if (tx_valid_q) begin
                        tx_shift_q <= tx_hold_q;
                    end else begin
                        underrun_q <= 1'b1;
                        if (urun_cnt_q != 16'hFFFF) urun_cnt_q <= urun_cnt_q + 16'd1;
                    end
                end else begin
                    drive_q <= RIGHT_DRIVE;
                end
            end else if (bclk_fall) begin
                fc_q  <= fc_d;
                dac_q <= dac_d;
            end

            // A ready edge coinciding with a load wins: the load used the old
            // hold/valid, and the new word waits for the following frame.
            if (er_rise) begin
                tx_hold_q  <= out_sample;
                tx_valid_q <= 1'b1;
            end else if (bclk_fall && slot_pend_q && slot_left_q) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    assign i2s_dac        = dac_q;
    assign in_sample      = in_sample_q;
    assign sample_ready   = sample_ready_q;
    assign underrun       = underrun_q;
    assign underrun_count = urun_cnt_q;
    assign frame_error    = frame_error_q;

endmodule

// File: tb/tb_i2s_sample_bridge.sv
// ---------------------------------------------------------------------------
// tb_i2s_sample_bridge
//   Directed bench: a codec model (BCLK = clk/8, data changes on falling
//   BCLK) drives frames with hand-picked left words and engine handshakes;
//   DAC bits are sampled just before each rising BCLK.
// ---------------------------------------------------------------------------
module tb_i2s_sample_bridge;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i2s_bclk = 1'b0;
    logic          i2s_lrclk = 1'b1;
    logic          i2s_adc = 1'b0;
    logic          i2s_dac;
    logic [DW-1:0] in_sample;
    logic          sample_ready;
    logic [DW-1:0] out_sample = '0;
    logic          engine_ready = 1'b0;
    logic          underrun;
    logic [15:0]   underrun_count;
    logic          frame_error;

    int n_chk = 0, n_err = 0;
    int rdy_n = 0, urun_n = 0, ferr_n = 0;
    int r0, u0, f0;
    logic [DW-1:0] dac_word, ldac, rdac;
    logic          dac_tail, ltail, rtail;

    always #5 clk = ~clk;

    i2s_sample_bridge #(.data_width(DW), .slot_width(32), .sync_stages(2)) dut (
        .clk(clk), .reset(reset),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_adc(i2s_adc), .i2s_dac(i2s_dac),
        .in_sample(in_sample), .sample_ready(sample_ready),
        .out_sample(out_sample), .engine_ready(engine_ready),
        .underrun(underrun), .underrun_count(underrun_count), .frame_error(frame_error)
    );

    // Pulse counters: a stuck output inflates the count.
    always @(negedge clk) begin
        if (sample_ready) rdy_n++;
        if (underrun)     urun_n++;
        if (frame_error)  ferr_n++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic snap();
        r0 = rdy_n; u0 = urun_n; f0 = ferr_n;
    endtask

    // One slot of nb BCLKs. Word MSB sits on rise 1. Engine_ready drops at
    // the slot start and rises at er_bit; reset pulses across bit rst_bit.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int nb,
                             input int er_bit, input logic [DW-1:0] er_val, input int rst_bit);
        logic [63:0] d;
        d = '0;
        for (int j = 0; j < nb; j++) begin
            i2s_bclk  = 1'b0;
            i2s_lrclk = lr;
            i2s_adc   = (j >= 1 && j <= DW) ? w[DW-j] : 1'b0;
            if (j == 0) engine_ready = 1'b0;
            if (j == er_bit) begin out_sample = er_val; engine_ready = 1'b1; end
            if (j == rst_bit) reset = 1'b1;
            repeat (4) @(negedge clk);
            d[j] = i2s_dac;
            if (j == rst_bit) begin
                chk("rst_in_sample", in_sample, 0);
                chk("rst_ready", sample_ready, 0);
                chk("rst_ucount", underrun_count, 0);
                chk("rst_dac", i2s_dac, 0);
                reset = 1'b0;
            end
            i2s_bclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        dac_tail = 1'b0;
        for (int j = 0; j < nb; j++) if (j < 2 || j > DW + 1) dac_tail |= d[j];
        for (int k = 0; k < DW; k++) dac_word[DW-1-k] = d[k+2];
    endtask

    task automatic frame(input logic [DW-1:0] lw, input int lnb, input int r_er_bit,
                         input logic [DW-1:0] r_er_val, input int l_rst_bit);
        snap();
        send_slot(1'b0, lw, lnb, -1, '0, l_rst_bit);
        ldac = dac_word; ltail = dac_tail;
        send_slot(1'b1, ~lw, 32, r_er_bit, r_er_val, -1);
        rdac = dac_word; rtail = dac_tail;
    endtask

    logic [DW-1:0] dup_exp;

    initial begin
        repeat (4) @(negedge clk);
        chk("reset_in_sample", in_sample, 0);
        chk("reset_ready", sample_ready, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_ucount", underrun_count, 0);
        chk("reset_ferr", frame_error, 0);
        chk("reset_dac", i2s_dac, 0);
        reset = 1'b0;
        @(negedge clk);

        // Pre-roll right slot: bridge stays in SYNC.
        snap();
        send_slot(1'b1, 16'hFFFF, 32, -1, '0, -1);
        chk("sync_no_ready", rdy_n - r0, 0);

        // 1: first left frame, nothing queued for TX.
        frame(16'h8001, 32, -1, '0, -1);
        chk("t1_ready_n", rdy_n - r0, 1);
        chk("t1_in_sample", in_sample, 16'h8001);
        chk("t1_ferr_n", ferr_n - f0, 0);
        chk("t1_urun_n", urun_n - u0, 1);
        chk("t1_ucount", underrun_count, 1);
        chk("t1_ldac", ldac, 0);

        // 2: engine supplies 0x1234 mid right slot.
        frame(16'h7FFE, 32, 8, 16'h1234, -1);
        chk("t2_in_sample", in_sample, 16'h7FFE);
        chk("t2_ucount", underrun_count, 2);

        frame(16'h0001, 32, 8, 16'h00FF, -1);
        chk("t2_ldac", ldac, 16'h1234);
        chk("t2_ltail", ltail, 0);
        chk("t2_urun_n", urun_n - u0, 0);
        chk("t2_in_sample", in_sample, 16'h0001);
`ifdef I2S_BRIDGE_STEREO_DUP_EN
        dup_exp = 16'h1234;
`else
        dup_exp = 16'h0000;
`endif
        chk("t2_rdac", rdac, dup_exp);

        // 3: 0x00FF sent, then the engine withholds ready for one frame.
        frame(16'hC3C3, 32, -1, '0, -1);
        chk("t3_ldac", ldac, 16'h00FF);
        chk("t3_urun_n0", urun_n - u0, 0);
        frame(16'h5A5A, 32, 8, 16'hA5A5, -1);
        chk("t3_urun_n1", urun_n - u0, 1);
        chk("t3_ucount", underrun_count, 3);
        chk("t3_ldac_rep", ldac, 16'h00FF);
        chk("t3_ltail", ltail, 0);

        // 6: left 0xA5A5, right slot per build option.
        frame(16'hFFFF, 32, -1, '0, -1);
        chk("t6_ldac", ldac, 16'hA5A5);
`ifdef I2S_BRIDGE_STEREO_DUP_EN
        dup_exp = 16'hA5A5;
`else
        dup_exp = 16'h0000;
`endif
        chk("t6_rdac", rdac, dup_exp);
        chk("t6_rtail", rtail, 0);
        chk("t6_in_sample", in_sample, 16'hFFFF);

        // 4: 10-BCLK left slot, then a full frame recovers.
        frame(16'h1111, 10, -1, '0, -1);
        chk("t4_ferr_n", ferr_n - f0, 1);
        chk("t4_ready_n", rdy_n - r0, 0);
        chk("t4_in_hold", in_sample, 16'hFFFF);
        frame(16'h1357, 32, -1, '0, -1);
        chk("t4_rec_ready_n", rdy_n - r0, 1);
        chk("t4_rec_in", in_sample, 16'h1357);
        chk("t4_rec_ferr_n", ferr_n - f0, 0);
        chk("t4_ucount", underrun_count, 5);

        // 5: reset at rc 7 of a left slot.
        frame(16'h2468, 32, -1, '0, 8);
        chk("t5_ready_n", rdy_n - r0, 0);
        chk("t5_ferr_n", ferr_n - f0, 0);
        chk("t5_in_sample", in_sample, 0);
        chk("t5_rdac", rdac, 0);
        frame(16'h2468, 32, -1, '0, -1);
        chk("t5_rec_ready_n", rdy_n - r0, 1);
        chk("t5_rec_in", in_sample, 16'h2468);
        chk("t5_rec_ucount", underrun_count, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
